// File: rtl/step_clock_gen_pkg.sv
// Shared definitions for the step clock generator.
//
// Contents:
//   state_t              processor-clock FSM states
//   DEF_* constants      default timing for a 100 MHz board clock
//   cnt_width()          counter width needed to hold values 0..n-1
//
// Optional behaviour STEP_CLOCK_RELEASE_STEP_EN is handled in btn_debounce.
package step_clk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STEP_HI,
    STEP_LO,
    RUN_HI,
    RUN_LO
  } state_t;

  // 10 ms debounce at 100 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  // clk cycles per phase of a single-step pulse
  localparam int unsigned DEF_HALF_CYCLES     = 4;
  // clk cycles per phase in run mode (1 Hz at 100 MHz)
  localparam int unsigned DEF_RUN_DIV         = 50000000;
  // step counter width
  localparam int unsigned DEF_CNT_W           = 16;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_clock_gen_if.sv
// Board-side signal bundle of the step clock generator.
//
// Signals:
//   btn_step      raw, bouncy, asynchronous step button
//   run_mode      raw asynchronous run switch (1 = free-run)
//   cpu_clk       registered processor clock
//   cpu_clk_rise  one-cycle strobe in the first cycle cpu_clk is 1
//   busy          generator is producing a clock period
//   step_count    cpu_clk rising edges since reset, wraps at 2^CNT_W
//
// Modports:
//   master  the board / environment: drives the controls, observes outputs
//   slave   the generator itself
interface step_clock_gen_if
  import step_clk_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             btn_step;
  logic             run_mode;
  logic             cpu_clk;
  logic             cpu_clk_rise;
  logic             busy;
  logic [CNT_W-1:0] step_count;

  modport master (
    output btn_step,
    output run_mode,
    input  cpu_clk,
    input  cpu_clk_rise,
    input  busy,
    input  step_count
  );

  modport slave (
    input  btn_step,
    input  run_mode,
    output cpu_clk,
    output cpu_clk_rise,
    output busy,
    output step_count
  );

endinterface

// File: rtl/step_clock_gen_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a debounce counter.
//
// Ports:
//   clk    board clock
//   reset  asynchronous, active-high
//   raw    raw asynchronous button level
//   deb    debounced button level
//   press  single-cycle event on an accepted debounced edge
//
// The synchronised level must differ from the debounced level for
// DEBOUNCE_CYCLES consecutive cycles before it is accepted; any cycle in
// which the two agree restarts the count.
//
// Build option STEP_CLOCK_RELEASE_STEP_EN: when defined, an accepted release
// (deb 1->0) raises press as well; otherwise only deb 0->1 does.
module btn_debounce
  import step_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic press
);

  localparam int unsigned    DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;
  logic          accept;
  logic          take;

  // New level has held long enough: it replaces deb on this edge.
  assign accept = (sync2 != deb) && (cnt == LAST);

`ifdef STEP_CLOCK_RELEASE_STEP_EN
  assign take = accept;
`else
  assign take = accept && sync2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= take;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (accept) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/step_clock_gen.sv
// Processor clock generator for the FPGA board.
//
// Produces a clean processor clock from the 100 MHz board clock, either one
// period per debounced step-button press or free-running while the run
// switch is on. Also counts processor clock rising edges for the display.
//
// Ports:
//   clk    board clock
//   reset  asynchronous, active-high
//   bus    step_clock_gen_if.slave:
//            btn_step, run_mode in; cpu_clk, cpu_clk_rise, busy, step_count out
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronised button level must hold
//   HALF_CYCLES      cycles per phase of a single-step pulse
//   RUN_DIV          cycles per phase in run mode
//   CNT_W            step_count width (must match the interface CNT_W)
//
// Build option STEP_CLOCK_RELEASE_STEP_EN: button releases also step
// (see btn_debounce).
//
// A phase is never cut short by a mode change: the run switch is only
// sampled in IDLE and at the end of RUN_LO, and presses outside IDLE are
// dropped. cpu_clk, cpu_clk_rise and step_count all update from next_state
// on the same edge, so the strobe and the count line up with the first
// high cycle of cpu_clk.
module step_clock_gen
  import step_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HALF_CYCLES     = DEF_HALF_CYCLES,
  parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  step_clock_gen_if.slave bus
);

  localparam int unsigned   PHASE_MAX = (HALF_CYCLES > RUN_DIV) ? HALF_CYCLES : RUN_DIV;
  localparam int unsigned   PW        = cnt_width(PHASE_MAX);
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] RUN_LAST  = PW'(RUN_DIV - 1);

  state_t           state;
  state_t           next_state;
  logic [PW-1:0]    phase;
  logic             run_s1;
  logic             run_sync;
  logic             press;
  logic             rise_next;
  logic             clk_next;
  logic             cpu_clk_q;
  logic             rise_q;
  logic [CNT_W-1:0] count_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_step),
    .deb   (),
    .press (press)
  );

  // run_mode is a slow switch: synchronised only, not debounced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_s1   <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_s1   <= bus.run_mode;
      run_sync <= run_s1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        // run has priority; a coincident press is discarded
        if (run_sync)   next_state = RUN_HI;
        else if (press) next_state = STEP_HI;
      end
      STEP_HI: if (phase == HALF_LAST) next_state = STEP_LO;
      STEP_LO: if (phase == HALF_LAST) next_state = IDLE;
      RUN_HI:  if (phase == RUN_LAST)  next_state = RUN_LO;
      RUN_LO:  if (phase == RUN_LAST)  next_state = run_sync ? RUN_HI : IDLE;
      default: next_state = IDLE;
    endcase

    clk_next  = (next_state == STEP_HI) || (next_state == RUN_HI);
    rise_next = clk_next && (next_state != state);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      cpu_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state     <= next_state;
      phase     <= (next_state != state) ? '0 : phase + PW'(1);
      cpu_clk_q <= clk_next;
      rise_q    <= rise_next;
      if (rise_next) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.cpu_clk      = cpu_clk_q;
  assign bus.cpu_clk_rise = rise_q;
  assign bus.busy         = (state != IDLE);
  assign bus.step_count   = count_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Scoreboard bench for step_clock_gen with DEBOUNCE_CYCLES=8, HALF_CYCLES=2,
// RUN_DIV=3, CNT_W=4. Stimulus pushes one record per expected cpu_clk period
// (rise cycle, high length, low length, step_count); the monitor pops one
// record on every cpu_clk_rise and measures the period it produces.
module tb_step_clock_gen;

  localparam int unsigned D   = 8;
  localparam int unsigned H   = 2;
  localparam int unsigned R   = 3;
  localparam int unsigned CW  = 4;
  localparam int unsigned LAT = D + 3;

`ifdef STEP_CLOCK_RELEASE_STEP_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  typedef struct {
    int unsigned   rise;
    int unsigned   hi;
    int unsigned   lo;
    logic [CW-1:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned steps = 0;
  exp_t        q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_clock_gen_if #(.CNT_W(CW)) bus ();

  step_clock_gen #(
    .DEBOUNCE_CYCLES (D),
    .HALF_CYCLES     (H),
    .RUN_DIV         (R),
    .CNT_W           (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_rise(input int unsigned at, input int unsigned hi, input int unsigned lo);
    exp_t e;
    steps++;
    e.rise = at;
    e.hi   = hi;
    e.lo   = lo;
    e.cnt  = steps[CW-1:0];
    q.push_back(e);
  endtask

  // Clean press held 20 cycles, then release held 20 cycles.
  task automatic press_release();
    bus.btn_step = 1'b1;
    expect_rise(cyc + LAT, H, H);
    tick(20);
    bus.btn_step = 1'b0;
    if (REL) expect_rise(cyc + LAT, H, H);
    tick(20);
  endtask

  // Monitor: phase 0 = waiting, 1 = measuring high, 2 = measuring low.
  exp_t        cur;
  int unsigned mphase = 0;
  int unsigned hi_cnt = 0;
  int unsigned lo_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      mphase = 0;
    end else begin
      if (mphase == 2 && (!bus.busy || bus.cpu_clk)) begin
        check("low_len", lo_cnt, cur.lo);
        mphase = 0;
      end
      if (bus.cpu_clk_rise) begin
        if (q.size() == 0) begin
          check("unexpected_rise", 0, 1);
          cur.hi = 0;
          cur.lo = 0;
        end else begin
          cur = q.pop_front();
          check("rise_cycle", cyc, cur.rise);
          check("rise_count", bus.step_count, cur.cnt);
          check("rise_clk", bus.cpu_clk, 1);
          check("rise_busy", bus.busy, 1);
        end
        mphase = 1;
        hi_cnt = 1;
      end else if (mphase == 1) begin
        if (bus.cpu_clk) hi_cnt++;
        else begin
          check("high_len", hi_cnt, cur.hi);
          mphase = 2;
          lo_cnt = 1;
        end
      end else if (mphase == 2) begin
        lo_cnt++;
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    total++;
    $display("FAIL watchdog: got cycle %0d, expected finish before 5000", cyc);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    int unsigned c0;
    reset        = 1'b1;
    bus.btn_step = 1'b0;
    bus.run_mode = 1'b0;
    tick(3);
    check("reset_cpu_clk", bus.cpu_clk, 0);
    check("reset_rise", bus.cpu_clk_rise, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_count", bus.step_count, 0);
    reset = 1'b0;
    tick(2);

    // clean press
    press_release();
    check("clean_count", bus.step_count, steps[CW-1:0]);

    // bounce: toggle every 3 cycles for 30 cycles, then hold high
    for (int k = 0; k < 10; k++) begin
      bus.btn_step = (k % 2 == 0);
      tick(3);
    end
    press_release();
    check("bounce_count", bus.step_count, steps[CW-1:0]);

    // press whose debounced event lands in RUN_LO is dropped
    bus.btn_step = 1'b1;
    tick(3);
    bus.run_mode = 1'b1;
    expect_rise(cyc + 3, R, R);
    tick(4);
    bus.run_mode = 1'b0;
    tick(20);
    check("drop_busy", bus.busy, 0);
    bus.btn_step = 1'b0;
    if (REL) expect_rise(cyc + LAT, H, H);
    tick(20);
    check("drop_count", bus.step_count, steps[CW-1:0]);

    // run mode for 40 cycles; dropped mid-RUN_HI of the 7th period
    bus.run_mode = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 7; k++) expect_rise(c0 + 3 + 6 * k, R, R);
    tick(40);
    bus.run_mode = 1'b0;
    tick(20);
    check("run_idle_busy", bus.busy, 0);
    check("run_count", bus.step_count, steps[CW-1:0]);

    // run switch rising mid-step: step completes, run starts from IDLE
    bus.btn_step = 1'b1;
    c0 = cyc;
    expect_rise(c0 + 11, H, H);
    expect_rise(c0 + 16, R, R);
    expect_rise(c0 + 22, R, R);
    tick(10);
    bus.run_mode = 1'b1;
    tick(10);
    bus.run_mode = 1'b0;
    tick(20);
    bus.btn_step = 1'b0;
    if (REL) expect_rise(cyc + LAT, H, H);
    tick(20);
    check("mid_step_run_count", bus.step_count, steps[CW-1:0]);

    // wrap of the 4-bit counter
    while (steps < 17) press_release();
    check("wrap_count", bus.step_count, steps[CW-1:0]);

    // reset in the second STEP_HI cycle, button held through reset
    bus.btn_step = 1'b1;
    expect_rise(cyc + LAT, H, H);
    tick(12);
    check("pre_reset_clk", bus.cpu_clk, 1);
    reset = 1'b1;
    #1;
    check("async_clk", bus.cpu_clk, 0);
    check("async_busy", bus.busy, 0);
    check("async_count", bus.step_count, 0);
    steps = 0;
    tick(3);
    reset = 1'b0;
    expect_rise(cyc + LAT, H, H);
    tick(20);
    bus.btn_step = 1'b0;
    if (REL) expect_rise(cyc + LAT, H, H);
    tick(20);
    check("post_reset_count", bus.step_count, steps[CW-1:0]);

    tick(10);
    check("leftover_expected", q.size(), 0);
    check("final_busy", bus.busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Generates the processor clock on the FPGA board from the 100 MHz board clock.
- Single-step mode: one debounced press of the step button produces exactly one clean processor clock period.
- Run mode: a run switch selects a free-running divided clock instead.
- Sits directly upstream of the board driver/CPU top. Its output replaces the raw button-toggled clock.
- Also provides a step counter for the seven-segment display mux.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised button level must hold before it is accepted (10 ms at 100 MHz).
- HALF_CYCLES, 4, clk cycles per phase (high, then low) of a single-step pulse.
- RUN_DIV, 50000000, clk cycles per phase in run mode (1 Hz at 100 MHz).
- CNT_W, 16, width of step_count.

Ports:
- clk  in  1  board clock.
- reset  in  1  reset.
- btn_step  in  1  raw, bouncy, asynchronous step button.
- run_mode  in  1  raw asynchronous switch; 1 selects free-run.
- cpu_clk  out  1  registered processor clock.
- cpu_clk_rise  out  1  one-clk-cycle strobe, high in the first cycle that cpu_clk is 1.
- busy  out  1  high whenever the FSM is not in IDLE.
- step_count  out  CNT_W  number of cpu_clk rising edges since reset.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- On reset:
  - state = IDLE.
  - cpu_clk = 0, cpu_clk_rise = 0, busy = 0, step_count = 0.
  - Sync flops = 0, debounced level = 0, all counters = 0.
- Synchronisation:
  - btn_step and run_mode each pass through a 2-FF synchroniser.
  - run_mode is synchronised only, not debounced.
- Debounce:
  - Counter clears whenever sync == deb.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 with sync != deb, deb <= sync and the counter clears.
  - A press event is a single-cycle flag raised on a deb 0->1 transition.
- FSM states: IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO. A phase counter clears on every state entry.
- IDLE (cpu_clk = 0):
  - run_sync = 1 -> RUN_HI.
  - Else a press event -> STEP_HI.
  - run_sync has priority when both occur in the same cycle; that press is discarded.
- STEP_HI (cpu_clk = 1): after HALF_CYCLES cycles -> STEP_LO.
- STEP_LO (cpu_clk = 0): after HALF_CYCLES cycles -> IDLE.
- RUN_HI (cpu_clk = 1): after RUN_DIV cycles -> RUN_LO.
- RUN_LO (cpu_clk = 0): after RUN_DIV cycles -> RUN_HI if run_sync = 1, else IDLE.
- Mode changes never truncate a phase:
  - run_mode dropping mid-RUN_HI completes both the high and low phases.
  - run_mode rising mid-step completes the step, then enters run from IDLE.
- Press events are dropped in every state except IDLE; they are not queued.
- cpu_clk is driven directly from a flop, never combinationally decoded. It is glitch-free.
- cpu_clk_rise is asserted in the first cycle of STEP_HI or RUN_HI.
- step_count increments on that same cycle and wraps modulo 2^CNT_W.
- Latency: a raw button edge that is stable thereafter produces cpu_clk = 1 exactly DEBOUNCE_CYCLES+3 clk cycles later.
- Button held through reset release: registers as one press after debounce.
- Reset mid-pulse: cpu_clk goes 0 immediately (asynchronous); no partial period is counted afterwards.

Optional Feature:
- Macro: STEP_CLOCK_RELEASE_STEP_EN.
- Defined: a debounced release (deb 1->0) also generates a press event. Each press-release pair therefore yields two processor clock periods, one per edge.
- Undefined: only deb 0->1 generates a step; releases are ignored.
- All other behaviour is identical in both builds.

Decomposition:
- Package step_clk_pkg holds:
  - the state enum (IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO);
  - default constants for DEBOUNCE_CYCLES, HALF_CYCLES and RUN_DIV.
- One sub-module, btn_debounce (2-FF sync plus debounce counter; outputs deb level and press event), instantiated once for btn_step.
- run_mode uses an inline 2-FF synchroniser.

Test Plan (bench parameters: DEBOUNCE_CYCLES=8, HALF_CYCLES=2, RUN_DIV=3):
- Clean press: btn_step 0->1 held -> cpu_clk high exactly 11 clk later for 2 cycles, then low for 2; cpu_clk_rise one cycle; step_count=1; busy for 4 cycles.
- Bounce: btn_step toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one cpu_clk period; step_count=1.
- Press while busy: second debounced press arrives during STEP_LO -> ignored; step_count stays 1.
- Run mode: run_mode=1 for 40 cycles -> cpu_clk period 6 cycles (3 high/3 low); deassert mid-RUN_HI -> phase completes, low phase completes, FSM returns to IDLE.
- Wrap: with CNT_W=4, 17 steps -> step_count=1.
- Reset mid-STEP_HI: cpu_clk and busy drop to 0 asynchronously; step_count=0; next press behaves as clean press. Repeat with STEP_CLOCK_RELEASE_STEP_EN defined: press plus release -> step_count=2.
